// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter: two request ports, two response
// handshakes, the shared result bus and the busy flag.
// slave  = arbiter side, master = requester side.
interface alu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_ovf;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_ovf, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_ovf, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared 32-bit adder/subtractor.
// Ops: 00 ADD, 01 SUB, 10 SLT (signed), 11 = SLTU when ALU_ARB_SLTU_EN is
// defined, otherwise identical to SLT.
// FIXED_PRIO = 0: round-robin on contention; 1: port 0 always wins.
module alu_share_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        port_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] data_q;
  logic        ovf_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;

  logic        grant_port;
  logic        accept;

  logic        sub_mode;
  logic [31:0] b_x;
  logic [31:0] sum;
  logic        sum_ovf;
  logic [31:0] alu_res;
  logic        alu_ovf;
`ifdef ALU_ARB_SLTU_EN
  logic        carry;
`endif

  // Grant selection; ready is gated by rst_n so it drops the instant reset asserts
  always_comb begin
    grant_port = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else
      grant_port = bus.req1_valid;
    accept = (state == IDLE) && rst_n && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = accept & ~grant_port;
  assign bus.req1_ready = accept &  grant_port;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.busy       = (state != IDLE);

  // Shared adder: subtraction and both compares use a + ~b + 1
  always_comb begin
    sub_mode = (op_q != 2'b00);
    b_x      = sub_mode ? ~b_q : b_q;
`ifdef ALU_ARB_SLTU_EN
    {carry, sum} = {1'b0, a_q} + {1'b0, b_x} + {32'd0, sub_mode};
`else
    sum = a_q + b_x + {31'd0, sub_mode};
`endif
    // with b_x already inverted for SUB, one rule covers both ADD and SUB
    sum_ovf = (a_q[31] == b_x[31]) && (sum[31] != a_q[31]);
    alu_res = sum;
    alu_ovf = sum_ovf;
    case (op_q)
      2'b00, 2'b01: begin
        alu_res = sum;
        alu_ovf = sum_ovf;
      end
      2'b10: begin
        alu_res = {31'd0, sum[31] ^ sum_ovf};
        alu_ovf = 1'b0;
      end
      default: begin
`ifdef ALU_ARB_SLTU_EN
        alu_res = {31'd0, ~carry};
`else
        alu_res = {31'd0, sum[31] ^ sum_ovf};
`endif
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Control FSM: IDLE accepts, EXEC computes for one cycle, RESP waits for the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      port_q       <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      ovf_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            port_q     <= grant_port;
            last_grant <= grant_port;
            op_q       <= grant_port ? bus.req1_op : bus.req0_op;
            a_q        <= grant_port ? bus.req1_a  : bus.req0_a;
            b_q        <= grant_port ? bus.req1_b  : bus.req0_b;
            state      <= EXEC;
          end
        end
        EXEC: begin
          data_q       <= alu_res;
          ovf_q        <= alu_ovf;
          rsp0_valid_q <= ~port_q;
          rsp1_valid_q <=  port_q;
          state        <= RESP;
        end
        RESP: begin
          if ((rsp0_valid_q && bus.rsp0_ready) || (rsp1_valid_q && bus.rsp1_ready)) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a transaction-level reference
// model tracks the expected phase of each accepted operation and computes
// results with plain integer arithmetic.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_share_arbiter_if intf ();
  alu_share_arbiter_if intf_fp ();

  alu_share_arbiter #(.FIXED_PRIO(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  alu_share_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Result reference: {ovf, data}
  function automatic logic [32:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint s;
    logic   ovf;
    logic [31:0] d;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    d   = '0;
    case (op)
      2'b00: begin
        s = sa + sb;
        d = s[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'b01: begin
        s = sa - sb;
        d = s[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'b10: d = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
`ifdef ALU_ARB_SLTU_EN
        d = (a < b) ? 32'd1 : 32'd0;
`else
        d = (sa < sb) ? 32'd1 : 32'd0;
`endif
      end
    endcase
    return {ovf, d};
  endfunction

  // Round-robin rule: contention goes to the port not granted last
  function automatic logic exp_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  // Reference model state (for the FIXED_PRIO=0 instance)
  int          m_phase;   // 0 idle, 1 computing, 2 responding
  logic        m_last;
  logic        m_port;
  logic [1:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;

  // Model advance on each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_last  <= 1'b1;
      m_port  <= 1'b0;
      m_op    <= '0;
      m_a     <= '0;
      m_b     <= '0;
    end else begin
      case (m_phase)
        0: if (intf.req0_valid || intf.req1_valid) begin
          m_port  <= exp_grant(intf.req0_valid, intf.req1_valid, m_last);
          m_last  <= exp_grant(intf.req0_valid, intf.req1_valid, m_last);
          m_op    <= exp_grant(intf.req0_valid, intf.req1_valid, m_last) ? intf.req1_op : intf.req0_op;
          m_a     <= exp_grant(intf.req0_valid, intf.req1_valid, m_last) ? intf.req1_a  : intf.req0_a;
          m_b     <= exp_grant(intf.req0_valid, intf.req1_valid, m_last) ? intf.req1_b  : intf.req0_b;
          m_phase <= 1;
        end
        1: m_phase <= 2;
        default: if ((!m_port && intf.rsp0_ready) || (m_port && intf.rsp1_ready)) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic        acc;
    logic        g;
    logic [32:0] r;
    #1;
    if (rst_n) begin
      acc = (m_phase == 0) && (intf.req0_valid || intf.req1_valid);
      g   = exp_grant(intf.req0_valid, intf.req1_valid, m_last);
      r   = ref_alu(m_op, m_a, m_b);
      check("m_ready0", intf.req0_ready, acc && !g);
      check("m_ready1", intf.req1_ready, acc && g);
      check("m_busy", intf.busy, m_phase != 0);
      check("m_rsp0_valid", intf.rsp0_valid, (m_phase == 2) && !m_port);
      check("m_rsp1_valid", intf.rsp1_valid, (m_phase == 2) && m_port);
      if (m_phase == 2) begin
        check("m_rsp_data", intf.rsp_data, r[31:0]);
        check("m_rsp_ovf", intf.rsp_ovf, r[32]);
      end
    end
  end

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic quiet_inputs();
    intf.req0_valid = 1'b0; intf.req0_op = '0; intf.req0_a = '0; intf.req0_b = '0;
    intf.req1_valid = 1'b0; intf.req1_op = '0; intf.req1_a = '0; intf.req1_b = '0;
    intf.rsp0_ready = 1'b1; intf.rsp1_ready = 1'b1;
  endtask

  // One complete transaction from IDLE with ready held high
  task automatic run_op(input string tag, input logic port, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_ovf);
    @(negedge clk);
    if (port) begin
      intf.req1_valid = 1'b1; intf.req1_op = op; intf.req1_a = a; intf.req1_b = b;
    end else begin
      intf.req0_valid = 1'b1; intf.req0_op = op; intf.req0_a = a; intf.req0_b = b;
    end
    #2 check({tag, "_accept"}, port ? intf.req1_ready : intf.req0_ready, 1'b1);
    @(negedge clk);
    intf.req0_valid = 1'b0; intf.req1_valid = 1'b0;
    #2 check({tag, "_exec_valid"}, port ? intf.rsp1_valid : intf.rsp0_valid, 1'b0);
    @(negedge clk);
    #2;
    check({tag, "_valid"}, port ? intf.rsp1_valid : intf.rsp0_valid, 1'b1);
    check({tag, "_data"}, intf.rsp_data, exp_data);
    check({tag, "_ovf"}, intf.rsp_ovf, exp_ovf);
  endtask

  int grants[$];
  int g0;
  int g1;

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    intf_fp.req0_valid = 1'b0; intf_fp.req0_op = '0; intf_fp.req0_a = '0; intf_fp.req0_b = '0;
    intf_fp.req1_valid = 1'b0; intf_fp.req1_op = '0; intf_fp.req1_a = '0; intf_fp.req1_b = '0;
    intf_fp.rsp0_ready = 1'b1; intf_fp.rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    intf.req0_valid = 1'b1; intf.req1_valid = 1'b1;
    #2;
    check("rst_ready0", intf.req0_ready, 1'b0);
    check("rst_ready1", intf.req1_ready, 1'b0);
    check("rst_busy", intf.busy, 1'b0);
    check("rst_rsp_data", intf.rsp_data, 32'h0);
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b1;

    // Directed corner operations
    run_op("add_ovf", 1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    run_op("slt_ovf", 1'b1, 2'b10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
    run_op("slt_pos", 1'b1, 2'b10, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0);
    run_op("sub_ovf", 1'b0, 2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
`ifdef ALU_ARB_SLTU_EN
    run_op("op3", 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
`else
    run_op("op3", 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
`endif

    // Response held off for 5 cycles while port 0 keeps requesting
    @(negedge clk);
    intf.req0_valid = 1'b1; intf.req0_op = 2'b00; intf.req0_a = 32'd10; intf.req0_b = 32'd20;
    intf.rsp0_ready = 1'b0;
    #2 check("hold_accept", intf.req0_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("hold_valid", intf.rsp0_valid, 1'b1);
      check("hold_data", intf.rsp_data, 32'd30);
      check("hold_ready", intf.req0_ready, 1'b0);
      check("hold_busy", intf.busy, 1'b1);
    end
    @(negedge clk);
    intf.req0_valid = 1'b0; intf.rsp0_ready = 1'b1;
    @(negedge clk);
    #2 check("hold_release_idle", intf.busy, 1'b0);

    // Asynchronous reset while an operation is in EXEC
    @(negedge clk);
    intf.req1_valid = 1'b1; intf.req1_op = 2'b00; intf.req1_a = 32'd1; intf.req1_b = 32'd2;
    @(negedge clk);
    intf.req0_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready0", intf.req0_ready, 1'b0);
    check("arst_ready1", intf.req1_ready, 1'b0);
    check("arst_rsp0", intf.rsp0_valid, 1'b0);
    check("arst_rsp1", intf.rsp1_valid, 1'b0);
    check("arst_data", intf.rsp_data, 32'h0);
    check("arst_ovf", intf.rsp_ovf, 1'b0);
    check("arst_busy", intf.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous contention after reset: first grant to port 0, then alternate
    intf.req0_op = 2'b00; intf.req0_a = 32'd100; intf.req0_b = 32'd1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      if (intf.req0_ready) grants.push_back(0);
      if (intf.req1_ready) grants.push_back(1);
    end
    check("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) check("rr_grant", grants[i], i % 2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      intf.req0_valid = ($urandom_range(0, 9) < 6);
      intf.req0_op    = 2'($urandom_range(0, 3));
      intf.req0_a     = rand_word();
      intf.req0_b     = rand_word();
      intf.req1_valid = ($urandom_range(0, 9) < 6);
      intf.req1_op    = 2'($urandom_range(0, 3));
      intf.req1_a     = rand_word();
      intf.req1_b     = rand_word();
      intf.rsp0_ready = ($urandom_range(0, 9) < 7);
      intf.rsp1_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    quiet_inputs();
    repeat (3) @(negedge clk);

    // Fixed-priority instance under continuous contention
    intf_fp.req0_valid = 1'b1; intf_fp.req0_op = 2'b00; intf_fp.req0_a = 32'd3; intf_fp.req0_b = 32'd4;
    intf_fp.req1_valid = 1'b1; intf_fp.req1_op = 2'b01; intf_fp.req1_a = 32'd9; intf_fp.req1_b = 32'd2;
    g0 = 0;
    g1 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      if (intf_fp.req0_ready) g0++;
      if (intf_fp.req1_ready) g1++;
      if (intf_fp.rsp0_valid) check("fp_data", intf_fp.rsp_data, 32'd7);
      check("fp_rsp1_valid", intf_fp.rsp1_valid, 1'b0);
    end
    check("fp_grants0", g0, 10);
    check("fp_grants1", g1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin grant, 1 = port 0 always wins.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  operation on port N accepted this cycle.
REQ-006 reqN_op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 per REQ-027/028.
REQ-007 reqN_a, reqN_b  input  32  operands, two's complement.
REQ-008 rspN_valid  output  1  result for port N available.
REQ-009 rspN_ready  input  1  port N consumes result.
REQ-010 rsp_data  output  32  shared result bus, valid only alongside rspN_valid.
REQ-011 rsp_ovf  output  1  signed overflow of the ADD/SUB performed; 0 for compare ops.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, EXEC, RESP; one shared 32-bit adder/subtractor serves both ports.
REQ-014 IDLE: if any reqN_valid, grant one port, drive its reqN_ready high combinationally for that cycle only, register op/a/b/port, go EXEC.
REQ-015 reqN_ready never high outside IDLE; never high for both ports in one cycle.
REQ-016 Both valid in IDLE, FIXED_PRIO=0: grant the port not granted last; last-grant pointer resets to 1 so port 0 wins first contention.
REQ-017 Both valid, FIXED_PRIO=1: port 0 granted.
REQ-018 EXEC (exactly one cycle): compute, register rsp_data/rsp_ovf, go RESP.
REQ-019 ADD: r = a+b mod 2^32; ovf = (a[31]==b[31]) && (r[31]!=a[31]).
REQ-020 SUB: r = a-b mod 2^32; ovf = (a[31]!=b[31]) && (r[31]!=a[31]).
REQ-021 SLT: d = a-b; rsp_data = {31 zeros, d[31] XOR sub-ovf}; rsp_ovf = 0.
REQ-022 RESP: assert rspN_valid of granted port only; hold rsp_data/rsp_ovf stable until rspN_ready; on rspN_ready return to IDLE.
REQ-023 Latency: accept at edge k -> rspN_valid high in cycle k+2; max throughput one op per 3 cycles.
REQ-024 rspN_ready sampled only in RESP; asserted elsewhere it has no effect.
REQ-025 reqN_valid dropping in EXEC/RESP does not cancel the accepted operation.

Reset
REQ-026 rst_n low: state IDLE, all ready/valid/rsp_data/rsp_ovf/busy 0, last-grant pointer 1, in-flight operation discarded, no response issued; effect immediate, independent of clk.

Configuration
REQ-027 Macro ALU_ARB_SLTU_EN defined: op 11 = SLTU, rsp_data = {31 zeros, borrow of a-b} (1 iff a<b unsigned), rsp_ovf = 0.
REQ-028 Macro undefined: op 11 executes identically to SLT (10); no unsigned-compare logic present.

Verification
REQ-029 Port0 ADD a=0x7FFFFFFF b=0x00000001 -> rsp0_valid 2 cycles after accept, rsp_data 0x80000000, rsp_ovf 1.
REQ-030 Port1 SLT a=0x80000000 b=0x00000001 -> rsp_data 0x00000001 (overflow case, MSB 0 XOR ovf 1); SLT a=5 b=-3 -> 0x00000000.
REQ-031 Both ports valid continuously, rspN_ready tied 1, FIXED_PRIO=0 -> grants alternate 0,1,0,1; FIXED_PRIO=1 -> port 0 only.
REQ-032 Hold rsp0_ready low 5 cycles in RESP -> rsp0_valid, rsp_data stable, req ready low, busy 1; release -> IDLE next cycle.
REQ-033 rst_n low during EXEC -> all outputs 0 asynchronously, no rspN_valid after release; next contention grants port 0.
REQ-034 op 11 a=0xFFFFFFFF b=1: ALU_ARB_SLTU_EN defined -> rsp_data 0; undefined -> rsp_data 1.
